// File: rtl/program_memory_loader_if.sv
// Byte-stream and memory-write bundle for program_memory_loader.
// master = byte source / memory side, slave = the loader itself.
interface program_memory_loader_if #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
);
  logic                          Start;
  logic [$clog2(MEMORY_DEPTH):0] WordCount;
  logic                          ByteValid;
  logic [7:0]                    ByteData;
  logic                          ByteReady;
  logic                          MemWrite;
  logic [DATA_WIDTH-1:0]         MemAddress;
  logic [DATA_WIDTH-1:0]         MemWriteData;
  logic                          Busy;
  logic                          Done;
  logic                          Error;

  modport master (
    output Start, WordCount, ByteValid, ByteData,
    input  ByteReady, MemWrite, MemAddress, MemWriteData, Busy, Done, Error
  );

  modport slave (
    input  Start, WordCount, ByteValid, ByteData,
    output ByteReady, MemWrite, MemAddress, MemWriteData, Busy, Done, Error
  );
endinterface

// File: rtl/program_memory_loader.sv
// Assembles a little-endian byte stream into 32-bit words and writes them to instruction memory.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module program_memory_loader #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32
) (
  input logic                  clk,
  input logic                  reset,
  program_memory_loader_if.slave bus
);
  localparam int CW = $clog2(MEMORY_DEPTH) + 1;

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_CHECK, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;
`endif

  state_t                r_state;
  state_t                w_next;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_word_idx;
  logic [1:0]            r_byte_idx;
  logic [DATA_WIDTH-1:0] r_word;
  logic                  r_error;
  logic                  w_len_bad;
  logic                  w_last_word;
  logic                  w_ready;
  logic                  w_mem_write;
  logic                  w_busy;
  logic                  w_done;
  logic [DATA_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_sum;
`endif

  assign w_len_bad   = (bus.WordCount == '0) || (bus.WordCount > CW'(MEMORY_DEPTH));
  assign w_last_word = (r_word_idx == (r_count - CW'(1)));

  always_comb begin
    w_next      = r_state;
    w_ready     = 1'b0;
    w_mem_write = 1'b0;
    w_busy      = 1'b1;
    w_done      = 1'b0;
    w_addr      = '0;
    w_wdata     = '0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (bus.Start) w_next = w_len_bad ? S_DONE : S_RECV;
      end
      S_RECV: begin
        w_ready = 1'b1;
        if (bus.ByteValid && (r_byte_idx == 2'd3)) w_next = S_WRITE;
      end
      S_WRITE: begin
        w_mem_write = 1'b1;
        w_addr      = {{(DATA_WIDTH-CW-2){1'b0}}, r_word_idx, 2'b00};
        w_wdata     = r_word;
        if (w_last_word) begin
`ifdef LOADER_CHECKSUM_EN
          w_next = S_CHECK;
`else
          w_next = S_DONE;
`endif
        end else begin
          w_next = S_RECV;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHECK: begin
        w_ready = 1'b1;
        if (bus.ByteValid) w_next = S_DONE;
      end
`endif
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_error    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            r_count    <= bus.WordCount;
            r_word_idx <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
            r_error    <= w_len_bad;
`ifdef LOADER_CHECKSUM_EN
            r_sum      <= '0;
`endif
          end
        end
        S_RECV: begin
          if (bus.ByteValid) begin
            r_word[{r_byte_idx, 3'b000} +: 8] <= bus.ByteData;
            // Byte index wraps 3 -> 0, ready for the next word.
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            r_sum      <= r_sum + bus.ByteData;
`endif
          end
        end
        S_WRITE: begin
          if (!w_last_word) r_word_idx <= r_word_idx + CW'(1);
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (bus.ByteValid) r_error <= r_error | (bus.ByteData != r_sum);
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.ByteReady    = w_ready;
  assign bus.MemWrite     = w_mem_write;
  assign bus.MemAddress   = w_addr;
  assign bus.MemWriteData = w_wdata;
  assign bus.Busy         = w_busy;
  assign bus.Done         = w_done;
  assign bus.Error        = r_error;
endmodule
